// File: rtl/vencoder_ctrl.sv
// vencoder_ctrl: frame sequencer for a rate-1/2, K=3 convolutional encoder.
// Steps the encoder one payload/tail bit at a time and serialises g0/g1 onto a backpressured symbol stream.
module vencoder_ctrl #(
   parameter int FRAME_LEN = 8,
   parameter int TAIL_LEN  = 2,
   parameter int CNT_W     = $clog2(FRAME_LEN + TAIL_LEN + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic abort,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   input  logic enc_g0,
   input  logic enc_g1,
   output logic enc_bit,
   output logic enc_shift,
   output logic enc_clear,
   output logic out_valid,
   output logic out_bit,
   output logic out_last,
   input  logic out_ready,
   output logic busy,
   output logic done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FETCH  = 3'd2,
      S_EMIT_A = 3'd3,
      S_EMIT_B = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cur_bit_q, cur_bit_d;
   logic             payload_phase_s;
   logic             last_bit_s;
   logic             abort_s;

   // Phase decodes: payload vs. tail, final coded bit, and an abort that applies only inside a frame.
   always_comb begin
      payload_phase_s = (cnt_q < FRAME_LEN_C);
      last_bit_s      = (cnt_q == LAST_IDX_C);
      abort_s         = abort && (state_q != S_IDLE);
      busy            = (state_q != S_IDLE);
   end

   // Next-state, counter and strobe decode; abort overrides every state transition.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_bit_d = cur_bit_q;
      in_ready  = 1'b0;
      enc_bit   = 1'b0;
      enc_shift = 1'b0;
      enc_clear = 1'b0;
      out_valid = 1'b0;
      out_bit   = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      if (abort_s) begin
         state_d   = S_IDLE;
         cnt_d     = {CNT_W{1'b0}};
         cur_bit_d = 1'b0;
         enc_clear = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CLEAR: begin
               enc_clear = 1'b1;
               cnt_d     = {CNT_W{1'b0}};
               state_d   = S_FETCH;
            end
            S_FETCH: begin
               if (payload_phase_s) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     cur_bit_d = in_bit;
                     state_d   = S_EMIT_A;
                  end else begin
                     state_d   = S_FETCH;
                  end
               end else begin
                  // Tail phase flushes zeros through the encoder without a handshake.
                  cur_bit_d = 1'b0;
                  state_d   = S_EMIT_A;
               end
            end
            S_EMIT_A: begin
               out_valid = 1'b1;
               out_bit   = enc_g0;
               enc_bit   = cur_bit_q;
               if (out_ready) begin
                  state_d = S_EMIT_B;
               end else begin
                  state_d = S_EMIT_A;
               end
            end
            S_EMIT_B: begin
               out_valid = 1'b1;
               out_bit   = enc_g1;
               enc_bit   = cur_bit_q;
               out_last  = last_bit_s;
               if (out_ready) begin
                  // g1 has just been consumed, so the encoder may now advance.
                  enc_shift = 1'b1;
                  cnt_d     = cnt_q + CNT_ONE_C;
                  if (last_bit_s) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_FETCH;
                  end
               end else begin
                  state_d = S_EMIT_B;
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d   = S_IDLE;
               cnt_d     = {CNT_W{1'b0}};
               cur_bit_d = 1'b0;
            end
         endcase
      end
   end

   // State, bit counter and the bit currently presented to the encoder.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         cur_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_bit_q <= cur_bit_d;
      end
   end

endmodule

// File: tb/tb_vencoder_ctrl.sv
// Bench for vencoder_ctrl: environment encoder (g0=111, g1=101) plus a convolution reference model.
module tb_vencoder_ctrl;
   localparam int FL   = 4;
   localparam int TL   = 2;
   localparam int NSYM = 2 * (FL + TL);

   logic clock = 1'b0;
   logic reset;
   logic start, abort, in_valid, in_bit, out_ready;
   logic in_ready, enc_g0, enc_g1, enc_bit, enc_shift, enc_clear;
   logic out_valid, out_bit, out_last, busy, done;
   logic start_b, abort_b, in_valid_b, in_bit_b, out_ready_b;
   logic in_ready_b, enc_g0_b, enc_g1_b, enc_bit_b, enc_shift_b, enc_clear_b;
   logic out_valid_b, out_bit_b, out_last_b, busy_b, done_b;
   logic [1:0] est_a = 2'b00;
   logic [1:0] est_b = 2'b00;

   int   checks = 0;
   int   errors = 0;
   logic got_q[$];
   logic exp_q[$];
   int   n_shift, n_clear, n_last, last_pos, n_done, n_hs, bad_shift;
   int   clear_cyc, done_cyc, last_cyc;
   bit   fin;
   logic brk_clr;
   logic [8:0] brk_outs;

   always #5 clock = ~clock;

   // Environment encoders: [1] is the newest bit, [0] the oldest.
   assign enc_g0   = enc_bit ^ est_a[1] ^ est_a[0];
   assign enc_g1   = enc_bit ^ est_a[0];
   assign enc_g0_b = enc_bit_b ^ est_b[1] ^ est_b[0];
   assign enc_g1_b = enc_bit_b ^ est_b[0];

   always @(posedge clock) begin
      if (enc_clear) est_a <= 2'b00;
      else if (enc_shift) est_a <= {enc_bit, est_a[1]};
      if (enc_clear_b) est_b <= 2'b00;
      else if (enc_shift_b) est_b <= {enc_bit_b, est_b[1]};
   end

   vencoder_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL)) dut_a (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .enc_g0(enc_g0), .enc_g1(enc_g1), .enc_bit(enc_bit),
      .enc_shift(enc_shift), .enc_clear(enc_clear),
      .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
      .out_ready(out_ready), .busy(busy), .done(done));

   vencoder_ctrl #(.FRAME_LEN(1), .TAIL_LEN(0)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
      .in_valid(in_valid_b), .in_bit(in_bit_b), .in_ready(in_ready_b),
      .enc_g0(enc_g0_b), .enc_g1(enc_g1_b), .enc_bit(enc_bit_b),
      .enc_shift(enc_shift_b), .enc_clear(enc_clear_b),
      .out_valid(out_valid_b), .out_bit(out_bit_b), .out_last(out_last_b),
      .out_ready(out_ready_b), .busy(busy_b), .done(done_b));

   // Reference: each coded bit b_i yields g0 = b_i+b_{i-1}+b_{i-2}, g1 = b_i+b_{i-2} (mod 2).
   task automatic build_expected(input logic [7:0] bits, input int fl, input int tl);
      int b, b1, b2;
      b1 = 0; b2 = 0;
      exp_q.delete();
      for (int i = 0; i < fl + tl; i++) begin
         b = (i < fl) ? int'(bits[i]) : 0;
         exp_q.push_back(((b + b1 + b2) % 2) == 1);
         exp_q.push_back(((b + b2) % 2) == 1);
         b2 = b1;
         b1 = b;
      end
   endtask

   // Drives one frame on dut_a. mode: 0 ready always, 1 ready 1-0-0-1, 2 random ready.
   // brk_kind: 1 abort when symbol brk_sym is presented, 2 async reset at that symbol.
   task automatic run_frame(input logic [FL-1:0] bits, input int gap, input int mode,
                            input bit glitch, input int brk_kind, input int brk_sym);
      int idx, gapc, pc, fcnt, cyc;
      bit st_fetch, st_emit, prev_stall, prev_bit, prev_last, g_fetch, g_emitb;
      logic [3:0] pat;
      pat = 4'b1001;
      got_q.delete();
      n_shift = 0; n_clear = 0; n_last = 0; last_pos = 0; n_done = 0; n_hs = 0; bad_shift = 0;
      clear_cyc = -1; done_cyc = -1; last_cyc = -1;
      idx = 0; gapc = gap; pc = 0; fcnt = 0; cyc = 0; fin = 1'b0;
      prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0; g_fetch = 1'b0; g_emitb = 1'b0;
      start = 1'b1;
      @(posedge clock); #1;
      while (!fin && cyc < 400) begin
         st_fetch = in_ready;
         st_emit  = out_valid;
         start    = 1'b0;
         in_valid = (idx < FL) && (gapc == 0);
         in_bit   = in_valid ? bits[idx] : 1'($urandom_range(1, 0));
         case (mode)
            1:       out_ready = pat[pc % 4];
            2:       out_ready = ($urandom_range(3, 0) != 0);
            default: out_ready = 1'b1;
         endcase
         pc++;
         if (glitch && !g_fetch && st_fetch && idx == 1) begin start = 1'b1; g_fetch = 1'b1; end
         if (glitch && !g_emitb && st_emit && (fcnt % 2) == 1 && fcnt >= 3) begin
            start = 1'b1; g_emitb = 1'b1;
         end
         if (brk_kind == 1 && st_emit && fcnt == brk_sym) abort = 1'b1;
         #1;
         if (abort) begin
            brk_clr = enc_clear;
            @(posedge clock); #1;
            abort = 1'b0;
            brk_outs = {in_ready, out_valid, out_bit, out_last, enc_shift, enc_clear, enc_bit, busy, done};
            fin = 1'b1;
         end else if (brk_kind == 2 && st_emit && fcnt == brk_sym) begin
            #1 reset = 1'b0;
            #1 brk_outs = {in_ready, out_valid, out_bit, out_last, enc_shift, enc_clear, enc_bit, busy, done};
            @(negedge clock); reset = 1'b1;
            @(posedge clock); #1;
            fin = 1'b1;
         end else begin
            if (prev_stall) begin
               checks++;
               if (out_valid !== 1'b1 || out_bit !== prev_bit || out_last !== prev_last) begin
                  errors++;
                  $display("FAIL stall_hold sym %0d: got v=%b b=%b l=%b want v=1 b=%b l=%b",
                           fcnt, out_valid, out_bit, out_last, prev_bit, prev_last);
               end
            end
            if (enc_shift) n_shift++;
            if (enc_shift && !(out_valid && out_ready)) bad_shift++;
            if (enc_clear) begin n_clear++; clear_cyc = cyc; end
            if (in_valid && in_ready) begin
               n_hs++; idx++; gapc = gap;
            end else if (in_ready && gapc > 0) begin
               gapc--;
            end
            if (out_valid && out_ready) begin
               got_q.push_back(out_bit);
               if (out_last) begin n_last++; last_pos = got_q.size(); end
               last_cyc = cyc;
               fcnt++;
            end
            if (done) begin n_done++; done_cyc = cyc; fin = 1'b1; end
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            prev_last  = out_last;
            @(posedge clock); #1;
            cyc++;
         end
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (!fin) begin errors++; $display("FAIL frame_timeout: got no done after %0d cycles, want done", cyc); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_bit, out_last, enc_shift, enc_clear, enc_bit, busy, done} !== 9'd0) begin
         errors++; $display("FAIL reset_a: got %b want 000000000",
            {in_ready, out_valid, out_bit, out_last, enc_shift, enc_clear, enc_bit, busy, done});
      end
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({in_ready_b, out_valid_b, out_bit_b, out_last_b, enc_shift_b, enc_clear_b, enc_bit_b, busy_b, done_b} !== 9'd0) begin
         errors++; $display("FAIL reset_b: got %b want 000000000",
            {in_ready_b, out_valid_b, out_bit_b, out_last_b, enc_shift_b, enc_clear_b, enc_bit_b, busy_b, done_b});
      end
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      build_expected({4'b0000, 4'b1101}, FL, TL);
      run_frame(4'b1101, 0, 0, 1'b0, 0, 0);
      checks++;
      if (got_q.size() != NSYM) begin errors++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), NSYM); end
      for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_sym%0d: got %b want %b", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (n_last != 1 || last_pos != NSYM) begin
         errors++; $display("FAIL basic_last: got count %0d pos %0d want 1 pos %0d", n_last, last_pos, NSYM);
      end
      checks++;
      if (n_done != 1 || done_cyc != last_cyc + 1) begin
         errors++; $display("FAIL basic_done: got %0d at %0d want 1 at %0d", n_done, done_cyc, last_cyc + 1);
      end
      checks++;
      if (n_clear != 1 || n_shift != FL + TL || bad_shift != 0) begin
         errors++; $display("FAIL basic_strobes: got clear %0d shift %0d bad %0d want 1 %0d 0", n_clear, n_shift, bad_shift, FL + TL);
      end
      checks++;
      if (n_hs != FL) begin errors++; $display("FAIL basic_handshakes: got %0d want %0d", n_hs, FL); end
      checks++;
      if (done_cyc - clear_cyc != 3 * (FL + TL) + 1) begin
         errors++; $display("FAIL basic_throughput: got %0d want %0d", done_cyc - clear_cyc, 3 * (FL + TL) + 1);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %b done %b want 0 0", busy, done); end
   endtask

   task automatic test_stall();
      build_expected({4'b0000, 4'b1101}, FL, TL);
      run_frame(4'b1101, 3, 1, 1'b0, 0, 0);
      checks++;
      if (got_q.size() != NSYM) begin errors++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), NSYM); end
      for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_sym%0d: got %b want %b", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (n_shift != FL + TL || bad_shift != 0 || n_hs != FL || last_pos != NSYM) begin
         errors++; $display("FAIL stall_counts: got shift %0d bad %0d hs %0d last %0d want %0d 0 %0d %0d",
                            n_shift, bad_shift, n_hs, last_pos, FL + TL, FL, NSYM);
      end
   endtask

   task automatic test_start_ignored();
      build_expected({4'b0000, 4'b1101}, FL, TL);
      for (int f = 0; f < 2; f++) begin
         run_frame(4'b1101, 0, 0, (f == 0), 0, 0);
         checks++;
         if (got_q.size() != NSYM) begin errors++; $display("FAIL start_len f%0d: got %0d want %0d", f, got_q.size(), NSYM); end
         for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL start_sym%0d f%0d: got %b want %b", i, f, got_q[i], exp_q[i]); end
         end
         checks++;
         if (n_clear != 1 || n_done != 1 || n_last != 1) begin
            errors++; $display("FAIL start_frame f%0d: got clear %0d done %0d last %0d want 1 1 1", f, n_clear, n_done, n_last);
         end
      end
   endtask

   task automatic test_abort();
      int late_done;
      run_frame(4'b1101, 0, 0, 1'b0, 1, 4);
      checks++;
      if (brk_clr !== 1'b1) begin errors++; $display("FAIL abort_clear: got %b want 1", brk_clr); end
      checks++;
      if (brk_outs !== 9'd0) begin errors++; $display("FAIL abort_idle: got %b want 000000000", brk_outs); end
      late_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (done || out_last || out_valid) late_done++;
         @(posedge clock); #1;
      end
      checks++;
      if (late_done != 0 || n_done != 0 || n_last != 0) begin
         errors++; $display("FAIL abort_quiet: got late %0d done %0d last %0d want 0 0 0", late_done, n_done, n_last);
      end
      build_expected({4'b0000, 4'b1101}, FL, TL);
      run_frame(4'b1101, 0, 0, 1'b0, 0, 0);
      checks++;
      if (got_q.size() != NSYM) begin errors++; $display("FAIL abort_next_len: got %0d want %0d", got_q.size(), NSYM); end
      for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_next_sym%0d: got %b want %b", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      run_frame(4'b1101, 0, 0, 1'b0, 2, 5);
      checks++;
      if (brk_outs !== 9'd0) begin errors++; $display("FAIL midreset_outs: got %b want 000000000", brk_outs); end
      build_expected({4'b0000, 4'b1101}, FL, TL);
      run_frame(4'b1101, 0, 0, 1'b0, 0, 0);
      checks++;
      if (got_q.size() != NSYM) begin errors++; $display("FAIL midreset_len: got %0d want %0d", got_q.size(), NSYM); end
      for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_sym%0d: got %b want %b", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      logic [FL-1:0] bits;
      int gap;
      for (int f = 0; f < 6; f++) begin
         bits = FL'($urandom);
         gap  = $urandom_range(2, 0);
         build_expected({4'b0000, bits}, FL, TL);
         run_frame(bits, gap, 2, 1'b0, 0, 0);
         checks++;
         if (got_q.size() != NSYM) begin errors++; $display("FAIL rand_len f%0d: got %0d want %0d", f, got_q.size(), NSYM); end
         for (int i = 0; i < NSYM && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rand_sym%0d f%0d bits %b: got %b want %b", i, f, bits, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (n_shift != FL + TL || bad_shift != 0 || n_hs != FL || last_pos != NSYM || n_done != 1) begin
            errors++; $display("FAIL rand_counts f%0d: got shift %0d bad %0d hs %0d last %0d done %0d", f, n_shift, bad_shift, n_hs, last_pos, n_done);
         end
      end
   endtask

   task automatic test_short_frame();
      int cyc, nsh, nclr, nhs, nlast, lastp, lastc, donec;
      logic gq[$];
      bit   ok;
      cyc = 0; nsh = 0; nclr = 0; nhs = 0; nlast = 0; lastp = 0; lastc = -1; donec = -1; ok = 1'b0;
      build_expected(8'b0000_0001, 1, 0);
      in_valid_b = 1'b1; in_bit_b = 1'b1; out_ready_b = 1'b1; start_b = 1'b1;
      @(posedge clock); #1;
      start_b = 1'b0;
      while (!ok && cyc < 50) begin
         if (out_valid_b && out_ready_b) begin
            gq.push_back(out_bit_b);
            if (out_last_b) begin nlast++; lastp = gq.size(); end
            lastc = cyc;
         end
         if (enc_shift_b) nsh++;
         if (enc_clear_b) nclr++;
         if (in_valid_b && in_ready_b) nhs++;
         if (done_b) begin donec = cyc; ok = 1'b1; end
         @(posedge clock); #1;
         cyc++;
      end
      in_valid_b = 1'b0; out_ready_b = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL short_timeout: got no done want done"); end
      checks++;
      if (gq.size() != 2) begin errors++; $display("FAIL short_len: got %0d want 2", gq.size()); end
      for (int i = 0; i < 2 && i < gq.size(); i++) begin
         checks++;
         if (gq[i] !== exp_q[i]) begin errors++; $display("FAIL short_sym%0d: got %b want %b", i, gq[i], exp_q[i]); end
      end
      checks++;
      if (nlast != 1 || lastp != 2 || donec != lastc + 1) begin
         errors++; $display("FAIL short_last: got last %0d pos %0d done@%0d want 1 2 done@%0d", nlast, lastp, donec, lastc + 1);
      end
      checks++;
      if (nsh != 1 || nclr != 1 || nhs != 1 || busy_b !== 1'b0) begin
         errors++; $display("FAIL short_strobes: got shift %0d clear %0d hs %0d busy %b want 1 1 1 0", nsh, nclr, nhs, busy_b);
      end
   endtask

   initial begin
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; in_valid_b = 1'b0; in_bit_b = 1'b0; out_ready_b = 1'b0;
      brk_clr = 1'b0; brk_outs = 9'd0;
      test_reset();
      test_basic();
      test_stall();
      test_start_ignored();
      test_abort();
      test_reset_midframe();
      test_random();
      test_short_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vencoder_ctrl.md
Name: vencoder_ctrl

Overview:
- Frame sequencer for the rate-1/2, K=3 convolutional encoder datapath in the Viterbi/PRML chain.
- Takes payload bits over a valid/ready handshake and steps the encoder one bit at a time.
- Appends TAIL_LEN zero flush bits per frame and serialises each encoder output pair (g0 then g1) onto a single-bit symbol stream with backpressure.
- Replaces free-running slow-clock stepping with explicit shift/clear strobes in the single system clock domain.

Parameters:
- FRAME_LEN, 8, payload bits per frame (>=1).
- TAIL_LEN, 2, zero flush bits appended per frame (K-1; 0 disables tailing).
- CNT_W, $clog2(FRAME_LEN+TAIL_LEN+1), width of the internal bit counter.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous frame abort; takes priority over all other inputs except reset.
- in_valid  in  1  payload bit valid.
- in_bit  in  1  payload bit.
- in_ready  out  1  controller accepts in_bit this cycle.
- enc_g0  in  1  encoder output 0 for the presented enc_bit (combinational from the encoder).
- enc_g1  in  1  encoder output 1 for the presented enc_bit.
- enc_bit  out  1  bit presented to the encoder input.
- enc_shift  out  1  one-cycle strobe: encoder shifts enc_bit into its register.
- enc_clear  out  1  one-cycle strobe: encoder register cleared to 0.
- out_valid  out  1  symbol valid.
- out_bit  out  1  coded symbol.
- out_last  out  1  marks the final symbol of the frame.
- out_ready  in  1  downstream accepts the symbol.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last symbol is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, cur_bit=0.
  - All outputs 0: in_ready, out_valid, out_bit, out_last, enc_shift, enc_clear, enc_bit, busy, done.
- States: IDLE, CLEAR, FETCH, EMIT_A, EMIT_B, DONE.
- IDLE: on start=1, go to CLEAR. start is ignored in every other state.
- CLEAR: enc_clear=1 for exactly this cycle; counter<=0; go to FETCH.
- FETCH:
  - If counter<FRAME_LEN: in_ready=1. On in_valid, cur_bit<=in_bit and go to EMIT_A.
  - Else (tail phase): in_ready=0, cur_bit<=0, go to EMIT_A without handshake.
- EMIT_A:
  - out_valid=1, out_bit=enc_g0, enc_bit=cur_bit.
  - On out_ready, go to EMIT_B.
- EMIT_B:
  - out_valid=1, out_bit=enc_g1, enc_bit=cur_bit.
  - out_last=1 when counter==FRAME_LEN+TAIL_LEN-1.
  - On out_ready: enc_shift=1 in that same cycle; counter<=counter+1.
  - Next state is DONE if this was the last symbol, else FETCH.
- DONE: done=1 for one cycle; go to IDLE.
- enc_bit holds cur_bit throughout EMIT_A and EMIT_B. g0 and g1 are taken from the same pre-shift encoder state.
- The encoder shifts only on an accepted EMIT_B symbol, never in any other state.
- Output stability: out_bit, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
- Frame length: exactly 2*(FRAME_LEN+TAIL_LEN) symbols per frame; exactly FRAME_LEN in_valid&in_ready handshakes per frame.
- Throughput:
  - Minimum 3 cycles per bit (FETCH, EMIT_A, EMIT_B) with in_valid and out_ready held high.
  - Frame overhead: CLEAR + DONE.
- abort=1 in any state other than IDLE:
  - Go to IDLE next cycle. enc_clear=1 in the abort cycle; counter<=0.
  - No done pulse. No out_last. In-flight symbol dropped; out_valid low from the next cycle.
- Reset mid-frame: immediate return to reset values. The encoder is cleared by the next frame's CLEAR state.
- Counter never exceeds FRAME_LEN+TAIL_LEN; no wrap-around is possible.

Test Plan:
- FRAME_LEN=4, TAIL_LEN=2, bench encoder model g0=111/g1=101, in 1,0,1,1, out_ready=1:
  - Required symbols: 1,1,1,0,0,0,0,1,0,1,1,1 (12 total).
  - out_last only on the 12th symbol; done 1 cycle later; enc_clear once; enc_shift exactly 6 times.
- Same frame with out_ready toggling 1-0-0-1 and in_valid gapped by 3 cycles:
  - Identical 12-symbol sequence.
  - out_bit stable while stalled; no enc_shift during stalls.
- start pulsed in FETCH and in EMIT_B mid-frame: ignored; frame completes normally; a second start after done starts a clean frame with one enc_clear.
- abort asserted in EMIT_A of bit 3:
  - IDLE next cycle; enc_clear=1 in the abort cycle; no done, no out_last.
  - Following frame 1,0,1,1 again gives the 12-symbol sequence above.
- reset driven low asynchronously mid-EMIT_B (between clock edges): all outputs 0 immediately; busy=0; next frame correct.
- TAIL_LEN=0, FRAME_LEN=1, in 1: symbols 1,1; out_last on 2nd; done follows; exactly one enc_shift.
